// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default frame geometry and the transmitter/receiver
// state encoding.
package i2s_pkg;

    localparam int FRAME_DEF   = 24;
    localparam int SLOT_DEF    = 32;
    localparam int MCK_DIV_DEF = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/i2s_tx_if.sv
// Parallel stereo sample handshake feeding the I2S transmitter.
interface i2s_tx_if
    import i2s_pkg::*;
#(
    parameter int FRAME = FRAME_DEF
) ();

    logic [FRAME-1:0] l_data;
    logic [FRAME-1:0] r_data;
    logic             valid;
    logic             ready;

    modport master (output l_data, r_data, valid, input ready);
    modport slave  (input l_data, r_data, valid, output ready);

endinterface

// File: rtl/i2s_clkgen.sv
// BCK/LRCK generator: MCK divider, bit position counter and frame tick.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter  int SLOT    = SLOT_DEF,
    parameter  int MCK_DIV = MCK_DIV_DEF,
    localparam int DW      = $clog2(MCK_DIV),
    localparam int BW      = $clog2(2 * SLOT)
) (
    input  logic          mck_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic          run_o,
    output logic          tick_o,
    output logic          lr_o,
    output logic [BW-1:0] bit_cnt_o,
    output logic          bck_o,
    output logic          lrck_o
);

    localparam logic [DW-1:0] DIV_LAST = DW'(MCK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(MCK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);

    logic [0:0]    state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          run;
    logic          active;

    assign run    = (state == ST_RUN);
    // Dropping en_i silences the outputs on the very next edge, not one later.
    assign active = run & en_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge mck_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            bck_o   <= 1'b0;
            lrck_o  <= 1'b0;
        end else begin
            bck_o  <= active && (div_cnt >= DIV_HALF);
            lrck_o <= active && (bit_cnt >= SLOT_B);
            if (!active) begin
                state   <= en_i ? ST_RUN : ST_IDLE;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    assign run_o     = active;
    assign tick_o    = run && (div_cnt == '0) && (bit_cnt == '0);
    assign lr_o      = (bit_cnt >= SLOT_B);
    assign bit_cnt_o = bit_cnt;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-pair holding buffer, active pair, MSB-first
// serialiser with the one-BCK I2S delay, and a sticky underrun flag.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int FRAME   = FRAME_DEF,
    parameter int SLOT    = SLOT_DEF,
    parameter int MCK_DIV = MCK_DIV_DEF
) (
    input  logic   mck_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  logic   clr_i,
    i2s_tx_if.slave smp,
    output logic   bck_o,
    output logic   lrck_o,
    output logic   data_o,
    output logic   frame_o,
    output logic   underrun_o
);

    localparam int BW = $clog2(2 * SLOT);
    localparam int IW = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic             run;
    logic             tick;
    logic             lr;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    pos;
    logic [FRAME-1:0] hold_l, hold_r;
    logic [FRAME-1:0] act_l, act_r;
    logic [FRAME-1:0] word;
    logic             hold_full;
    logic             accept;
    logic             ser_bit;

    i2s_clkgen #(
        .SLOT    (SLOT),
        .MCK_DIV (MCK_DIV)
    ) u_clkgen (
        .mck_i     (mck_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .run_o     (run),
        .tick_o    (tick),
        .lr_o      (lr),
        .bit_cnt_o (bit_cnt),
        .bck_o     (bck_o),
        .lrck_o    (lrck_o)
    );

    assign smp.ready = ~hold_full;
    assign accept    = smp.valid & ~hold_full;

    // NOTE: every variable written here gets a default first, so no latch is
    // inferred on the padding and delay-bit positions.
    always_comb begin
        pos     = lr ? bit_cnt - BW'(SLOT) : bit_cnt;
        word    = lr ? act_r : act_l;
        ser_bit = 1'b0;
        if (pos >= BW'(1) && pos <= BW'(FRAME))
            ser_bit = word[IW'(FRAME - int'(pos))];
    end

    // NOTE: the sample registers are plain flops, not a memory, so they are
    // reset along with the control state and a reset discards any buffered pair.
    always_ff @(posedge mck_i) begin
        if (rst_i) begin
            hold_l     <= '0;
            hold_r     <= '0;
            act_l      <= '0;
            act_r      <= '0;
            hold_full  <= 1'b0;
            data_o     <= 1'b0;
            frame_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            data_o  <= run & ser_bit;
            frame_o <= tick;
            if (tick) begin
                act_l <= hold_full ? hold_l : '0;
                act_r <= hold_full ? hold_r : '0;
            end
            // An accept on the tick itself lands in hold for the next frame.
            if (accept) begin
                hold_l    <= smp.l_data;
                hold_r    <= smp.r_data;
                hold_full <= 1'b1;
            end else if (tick) begin
                hold_full <= 1'b0;
            end
            if (tick && !hold_full)
                underrun_o <= 1'b1;
            else if (clr_i)
                underrun_o <= 1'b0;
        end
    end

endmodule
